rv32i_control_fsm: RTL and testbench
====================================

# rv32i_control_fsm

Multi-cycle sequencer for the RV32I core. It owns the PC and steps each instruction through fetch, decode, execute, memory and writeback, driving the instruction-register, memory-handshake and register-file-write strobes. It consumes the class flags produced by the instruction decoder and halts on system instructions, illegal encodings, misaligned control transfers and bus timeouts.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 16, maximum wait cycles for `imem_ready`/`dmem_ready` before trapping (≥1).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_valid  out  1  instruction fetch request; address is `pc`.
- imem_ready  in  1  instruction word is present this cycle.
- ir_en  out  1  latch strobe for the instruction register; equals imem_valid & imem_ready.
- dec_alu, dec_load, dec_store, dec_branch, dec_jump, dec_fence, dec_ecall, dec_ebreak  in  1 each  decoder class flags; dec_alu covers lui/auipc/OP/OP-IMM.
- br_taken  in  1  branch condition from the ALU, valid in EXEC.
- target  in  32  branch/jump target from the datapath, valid in EXEC.
- dmem_valid  out  1  data access request.
- dmem_we  out  1  store when 1, load when 0; qualified by dmem_valid.
- dmem_ready  in  1  access completes this cycle.
- rf_we  out  1  register-file write enable.
- wb_sel  out  2  00 ALU, 01 load data, 10 PC+4.
- pc  out  32  current PC.
- resume  in  1  leave HALT.
- halted  out  1  HALT state.
- trap_cause  out  3  0 none, 1 ecall, 2 ebreak, 3 illegal, 4 misaligned target, 5 bus timeout.
- instret  out  32  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. All strobes are Moore decodes of the registered state.
- FETCH: imem_valid=1. On imem_ready, go to DECODE. If the wait counter reaches MEM_TIMEOUT first, go to HALT with cause 5.
- DECODE: dec_ecall goes to HALT with cause 1. dec_ebreak goes to HALT with cause 2. No flag set goes to HALT with cause 3. Otherwise go to EXEC.
- EXEC: if the instruction is a taken control transfer (dec_jump, or dec_branch & br_taken) and target[1:0]≠0, go to HALT with cause 4 and leave pc unchanged. Loads and stores go to MEM. Everything else goes to WB.
- MEM: dmem_valid=1 and dmem_we=dec_store. On dmem_ready, go to WB. A timeout goes to HALT with cause 5.
- WB: rf_we=dec_alu|dec_load|dec_jump.
  - wb_sel is 10 for jump, 01 for load, 00 otherwise.
  - pc ← taken ? target : pc+4.
  - instret increments.
  - Go to FETCH.
- Fence and store write nothing; branches write nothing.
- HALT: halted=1 and trap_cause is held. On resume, pc←pc+4, cause←0, go to FETCH. A trapped instruction is never counted in instret.
- Handshake: valid stays high and stable until ready or timeout. A request is never withdrawn otherwise.
- The wait counter clears on entry to FETCH and MEM and increments each waiting cycle.
- If ready arrives on the same cycle the counter reaches MEM_TIMEOUT, ready wins.
- pc+4 and instret wrap modulo 2^32.
- Decoder flags and target must be held stable by the datapath from DECODE through WB. The instruction register holds them.

## Timing
- Reset (rst_n=0 at an edge) sets state=FETCH, pc=RESET_PC, instret=0 and trap_cause=0.
- Reset value of every output: halted=0, dmem_valid=0, dmem_we=0, rf_we=0, wb_sel=00, ir_en=0, trap_cause=0.
- imem_valid=1 in the first cycle after reset, because the state is FETCH.
- Reset mid-operation abandons any outstanding request at that edge.
- Latency with zero-wait memory:
  - ALU, branch, jump and fence take 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load and store take 5 cycles.
  - Each wait cycle adds one.
- A trap enters HALT on the edge that ends DECODE, EXEC, FETCH or MEM. halted rises the following cycle.
- resume is sampled only in HALT. imem_valid rises the cycle after resume.

## Structure
- Package `rv_ctrl_pkg` holds:
  - the state enum;
  - the trap cause constants (CAUSE_NONE…CAUSE_TIMEOUT);
  - the wb_sel encodings (WB_ALU, WB_LOAD, WB_PC4).
- Sub-module `bus_wait_counter` holds the wait counter. Parameter MEM_TIMEOUT; inputs clk, rst_n, clear, wait_en; output expired. One instance is shared by FETCH and MEM.

## Test plan
- Reset then zero-wait ADDI: imem_valid in cycle 1, rf_we=1 with wb_sel=00 in cycle 4, pc 0→4, instret=1.
- Taken BEQ with target=0x40 and no waits: pc=0x40 after WB, rf_we=0 throughout. Not-taken branch gives pc=4.
- LW with dmem_ready delayed 3 cycles: dmem_valid high 4 cycles, dmem_we=0, WB with wb_sel=01, total 8 cycles.
- JAL with target=0x102: HALT, trap_cause=4, pc unchanged, instret unchanged, no rf_we pulse.
- ECALL then resume: halted=1, cause=1. After resume, pc=old+4 and fetch restarts; all flags zero gives cause 3.
- imem_ready never asserted with MEM_TIMEOUT=16: HALT with cause 5 after 16 wait cycles. Ready on exactly the 16th cycle proceeds to DECODE. rst_n low mid-MEM resets to FETCH with pc=RESET_PC.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control sequencer.
package rv_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_t;

   localparam logic [2:0] CAUSE_NONE     = 3'd0;
   localparam logic [2:0] CAUSE_ECALL    = 3'd1;
   localparam logic [2:0] CAUSE_EBREAK   = 3'd2;
   localparam logic [2:0] CAUSE_ILLEGAL  = 3'd3;
   localparam logic [2:0] CAUSE_MISALIGN = 3'd4;
   localparam logic [2:0] CAUSE_TIMEOUT  = 3'd5;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;

   // Writeback source: link address for jumps, memory data for loads, ALU result otherwise.
   function automatic logic [1:0] wb_source(input logic is_jump, input logic is_load);
      if (is_jump)
         return WB_PC4;
      else if (is_load)
         return WB_LOAD;
      else
         return WB_ALU;
   endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Counts cycles a bus request has waited and flags the cycle on which the
// wait budget runs out. Shared between instruction fetch and data access.
module bus_wait_counter #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic wait_en,
   output logic expired
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   logic [CW-1:0] count;

   // Waiting-cycle counter; cleared while no request is outstanding.
   always_ff @(posedge clk) begin
      if (!rst_n || clear)
         count <= '0;
      else if (wait_en && !expired)
         count <= count + CW'(1);
   end

   // Expiry fires on the MEM_TIMEOUT-th waiting cycle; a ready in that cycle
   // suppresses wait_en, so ready takes precedence.
   always_comb begin
      expired = wait_en && (count == CW'(MEM_TIMEOUT - 1));
   end

endmodule

// File: rtl/rv32i_control_fsm.sv
// Multi-cycle sequencer for the RV32I core: owns the PC, steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and traps into HALT.
module rv32i_control_fsm
   import rv_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_valid,
   input  logic        imem_ready,
   output logic        ir_en,
   input  logic        dec_alu,
   input  logic        dec_load,
   input  logic        dec_store,
   input  logic        dec_branch,
   input  logic        dec_jump,
   input  logic        dec_fence,
   input  logic        dec_ecall,
   input  logic        dec_ebreak,
   input  logic        br_taken,
   input  logic [31:0] target,
   output logic        dmem_valid,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic [31:0] pc,
   input  logic        resume,
   output logic        halted,
   output logic [2:0]  trap_cause,
   output logic [31:0] instret
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instret_q, instret_d;
   logic [2:0]  cause_q, cause_d;
   logic        taken_q, taken_d;

   logic        wait_en;
   logic        wait_clear;
   logic        expired;
   logic        is_taken;
   logic        any_class;

   bus_wait_counter #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wait_clear),
      .wait_en (wait_en),
      .expired (expired)
   );

   // Control registers; reset restarts fetch at RESET_PC and abandons any request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         instret_q <= '0;
         cause_q   <= CAUSE_NONE;
         taken_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instret_q <= instret_d;
         cause_q   <= cause_d;
         taken_q   <= taken_d;
      end
   end

   // Next-state logic and Moore strobes decoded from the registered state.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instret_d  = instret_q;
      cause_d    = cause_q;
      taken_d    = taken_q;
      imem_valid = 1'b0;
      ir_en      = 1'b0;
      dmem_valid = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      wb_sel     = WB_ALU;
      halted     = 1'b0;
      wait_en    = 1'b0;
      // The counter only runs while a bus request is outstanding, so holding
      // it clear elsewhere means it starts from zero on every FETCH/MEM entry.
      wait_clear = !((state_q == ST_FETCH) || (state_q == ST_MEM));
      is_taken   = dec_jump || (dec_branch && br_taken);
      any_class  = dec_alu || dec_load || dec_store || dec_branch ||
                   dec_jump || dec_fence || dec_ecall || dec_ebreak;

      case (state_q)
         ST_FETCH: begin
            imem_valid = 1'b1;
            ir_en      = imem_ready;
            wait_en    = !imem_ready;
            if (imem_ready) begin
               state_d = ST_DECODE;
            end else if (expired) begin
               state_d = ST_HALT;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (dec_ecall) begin
               state_d = ST_HALT;
               cause_d = CAUSE_ECALL;
            end else if (dec_ebreak) begin
               state_d = ST_HALT;
               cause_d = CAUSE_EBREAK;
            end else if (!any_class) begin
               state_d = ST_HALT;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // br_taken is only valid here, so the decision is captured for WB.
            taken_d = is_taken;
            if (is_taken && (target[1:0] != 2'b00)) begin
               state_d = ST_HALT;
               cause_d = CAUSE_MISALIGN;
            end else if (dec_load || dec_store) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            dmem_valid = 1'b1;
            dmem_we    = dec_store;
            wait_en    = !dmem_ready;
            if (dmem_ready) begin
               state_d = ST_WB;
            end else if (expired) begin
               state_d = ST_HALT;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         ST_WB: begin
            rf_we     = dec_alu || dec_load || dec_jump;
            wb_sel    = wb_source(dec_jump, dec_load);
            pc_d      = taken_q ? target : (pc_q + 32'd4);
            instret_d = instret_q + 32'd1;
            state_d   = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
            if (resume) begin
               pc_d    = pc_q + 32'd4;
               cause_d = CAUSE_NONE;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Architectural state exported directly from the registers.
   always_comb begin
      pc         = pc_q;
      instret    = instret_q;
      trap_cause = cause_q;
   end

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Self-checking bench for rv32i_control_fsm: an instruction-level model
// pushes expected outcomes to a scoreboard, compared when the DUT retires or halts.
module tb_rv32i_control_fsm;
   import rv_ctrl_pkg::*;

   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam int          MEM_TIMEOUT = 16;
   localparam int          NEVER       = 1000;
   localparam int          BUDGET      = 200;

   localparam int K_NONE   = 0;
   localparam int K_ALU    = 1;
   localparam int K_LOAD   = 2;
   localparam int K_STORE  = 3;
   localparam int K_BRANCH = 4;
   localparam int K_JUMP   = 5;
   localparam int K_FENCE  = 6;
   localparam int K_ECALL  = 7;
   localparam int K_EBREAK = 8;

   logic        clk;
   logic        rst_n;
   logic        imem_valid, imem_ready, ir_en;
   logic        dec_alu, dec_load, dec_store, dec_branch;
   logic        dec_jump, dec_fence, dec_ecall, dec_ebreak;
   logic        br_taken;
   logic [31:0] target;
   logic        dmem_valid, dmem_we, dmem_ready;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic [31:0] pc;
   logic        resume;
   logic        halted;
   logic [2:0]  trap_cause;
   logic [31:0] instret;

   rv32i_control_fsm #(
      .RESET_PC    (RESET_PC),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_valid (imem_valid),
      .imem_ready (imem_ready),
      .ir_en      (ir_en),
      .dec_alu    (dec_alu),
      .dec_load   (dec_load),
      .dec_store  (dec_store),
      .dec_branch (dec_branch),
      .dec_jump   (dec_jump),
      .dec_fence  (dec_fence),
      .dec_ecall  (dec_ecall),
      .dec_ebreak (dec_ebreak),
      .br_taken   (br_taken),
      .target     (target),
      .dmem_valid (dmem_valid),
      .dmem_we    (dmem_we),
      .dmem_ready (dmem_ready),
      .rf_we      (rf_we),
      .wb_sel     (wb_sel),
      .pc         (pc),
      .resume     (resume),
      .halted     (halted),
      .trap_cause (trap_cause),
      .instret    (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          cycles;
      int          rf_pulses;
      logic [1:0]  wb_sel;
      int          dmem_cycles;
      logic        dmem_we;
      int          ir_pulses;
      logic [31:0] pc;
      logic [31:0] instret;
      logic        halted;
      logic [2:0]  cause;
   } outcome_t;

   outcome_t    sb[$];
   int          passed;
   int          total;
   logic [31:0] m_pc;
   logic [31:0] m_instret;

   task automatic set_flags(input int kind);
      dec_alu    = (kind == K_ALU);
      dec_load   = (kind == K_LOAD);
      dec_store  = (kind == K_STORE);
      dec_branch = (kind == K_BRANCH);
      dec_jump   = (kind == K_JUMP);
      dec_fence  = (kind == K_FENCE);
      dec_ecall  = (kind == K_ECALL);
      dec_ebreak = (kind == K_EBREAK);
   endtask

   // Drives one instruction from a FETCH negedge until it retires or halts.
   task automatic run_instr(input string name, input int kind, input logic br,
                            input logic [31:0] tgt, input int idelay, input int ddelay);
      outcome_t e, o;
      logic     taken, is_mem, done, left_fetch;
      int       iw, dw;
      e = '{cycles:0, rf_pulses:0, wb_sel:2'b00, dmem_cycles:0, dmem_we:1'b0,
            ir_pulses:1, pc:32'h0, instret:32'h0, halted:1'b0, cause:3'd0};
      o = e;
      o.ir_pulses = 0;
      is_mem = (kind == K_LOAD) || (kind == K_STORE);
      taken  = (kind == K_JUMP) || ((kind == K_BRANCH) && br);
      if (idelay >= MEM_TIMEOUT) begin
         e.cycles = MEM_TIMEOUT; e.ir_pulses = 0; e.halted = 1'b1; e.cause = 3'd5;
      end else if (kind == K_ECALL) begin
         e.cycles = idelay + 2; e.halted = 1'b1; e.cause = 3'd1;
      end else if (kind == K_EBREAK) begin
         e.cycles = idelay + 2; e.halted = 1'b1; e.cause = 3'd2;
      end else if (kind == K_NONE) begin
         e.cycles = idelay + 2; e.halted = 1'b1; e.cause = 3'd3;
      end else if (taken && (tgt[1:0] != 2'b00)) begin
         e.cycles = idelay + 3; e.halted = 1'b1; e.cause = 3'd4;
      end else if (is_mem && (ddelay >= MEM_TIMEOUT)) begin
         e.cycles = idelay + 3 + MEM_TIMEOUT; e.dmem_cycles = MEM_TIMEOUT;
         e.dmem_we = (kind == K_STORE); e.halted = 1'b1; e.cause = 3'd5;
      end else begin
         e.cycles      = idelay + 4 + (is_mem ? ddelay + 1 : 0);
         e.dmem_cycles = is_mem ? ddelay + 1 : 0;
         e.dmem_we     = (kind == K_STORE);
         e.rf_pulses   = ((kind == K_ALU) || (kind == K_LOAD) || (kind == K_JUMP)) ? 1 : 0;
         e.wb_sel      = (kind == K_JUMP) ? 2'b10 : ((kind == K_LOAD) ? 2'b01 : 2'b00);
         m_pc          = taken ? tgt : m_pc + 32'd4;
         m_instret     = m_instret + 32'd1;
      end
      e.pc      = m_pc;
      e.instret = m_instret;
      sb.push_back(e);

      set_flags(kind);
      br_taken = br;
      target   = tgt;
      iw = 0; dw = 0; done = 1'b0; left_fetch = 1'b0;
      while (!done && (o.cycles < BUDGET)) begin
         if (halted) begin
            done = 1'b1;
         end else if (imem_valid && left_fetch) begin
            done = 1'b1;
         end else begin
            o.cycles++;
            if (imem_valid) begin
               imem_ready = (iw == idelay);
               iw++;
            end else begin
               imem_ready = 1'b0;
               left_fetch = 1'b1;
            end
            if (dmem_valid) begin
               dmem_ready = (dw == ddelay);
               dw++;
               o.dmem_cycles++;
               o.dmem_we = o.dmem_we | dmem_we;
            end else begin
               dmem_ready = 1'b0;
            end
            if (rf_we) begin
               o.rf_pulses++;
               o.wb_sel = wb_sel;
            end
            #1;
            if (ir_en) o.ir_pulses++;
            @(negedge clk);
         end
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      o.halted  = halted;
      o.cause   = trap_cause;
      o.pc      = pc;
      o.instret = instret;

      e = sb.pop_front();
      total++;
      if (!done) $display("FAIL %s completion: got none within %0d cycles, want end after %0d", name, BUDGET, e.cycles);
      else passed++;
      total++;
      if (o.cycles !== e.cycles) $display("FAIL %s cycles: got %0d want %0d", name, o.cycles, e.cycles);
      else passed++;
      total++;
      if (o.rf_pulses !== e.rf_pulses) $display("FAIL %s rf_we pulses: got %0d want %0d", name, o.rf_pulses, e.rf_pulses);
      else passed++;
      total++;
      if (o.wb_sel !== e.wb_sel) $display("FAIL %s wb_sel: got %b want %b", name, o.wb_sel, e.wb_sel);
      else passed++;
      total++;
      if (o.dmem_cycles !== e.dmem_cycles) $display("FAIL %s dmem_valid cycles: got %0d want %0d", name, o.dmem_cycles, e.dmem_cycles);
      else passed++;
      total++;
      if (o.dmem_we !== e.dmem_we) $display("FAIL %s dmem_we: got %b want %b", name, o.dmem_we, e.dmem_we);
      else passed++;
      total++;
      if (o.ir_pulses !== e.ir_pulses) $display("FAIL %s ir_en pulses: got %0d want %0d", name, o.ir_pulses, e.ir_pulses);
      else passed++;
      total++;
      if (o.pc !== e.pc) $display("FAIL %s pc: got %h want %h", name, o.pc, e.pc);
      else passed++;
      total++;
      if (o.instret !== e.instret) $display("FAIL %s instret: got %0d want %0d", name, o.instret, e.instret);
      else passed++;
      total++;
      if (o.halted !== e.halted) $display("FAIL %s halted: got %b want %b", name, o.halted, e.halted);
      else passed++;
      total++;
      if (o.cause !== e.cause) $display("FAIL %s trap_cause: got %0d want %0d", name, o.cause, e.cause);
      else passed++;
   endtask

   // Leaves HALT from a negedge in HALT and checks the restart.
   task automatic do_resume(input string name);
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      m_pc = m_pc + 32'd4;
      total++;
      if (imem_valid !== 1'b1) $display("FAIL %s imem_valid after resume: got %b want 1", name, imem_valid);
      else passed++;
      total++;
      if (halted !== 1'b0) $display("FAIL %s halted after resume: got %b want 0", name, halted);
      else passed++;
      total++;
      if (trap_cause !== 3'd0) $display("FAIL %s cause after resume: got %0d want 0", name, trap_cause);
      else passed++;
      total++;
      if (pc !== m_pc) $display("FAIL %s pc after resume: got %h want %h", name, pc, m_pc);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; resume = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      br_taken = 1'b0; target = 32'h0; set_flags(K_NONE);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_pc = RESET_PC; m_instret = 32'd0;
      total++;
      if (imem_valid !== 1'b1) $display("FAIL reset imem_valid: got %b want 1", imem_valid);
      else passed++;
      total++;
      if ({halted, dmem_valid, dmem_we, rf_we, ir_en} !== 5'b0)
         $display("FAIL reset strobes: got %b want 00000", {halted, dmem_valid, dmem_we, rf_we, ir_en});
      else passed++;
      total++;
      if (wb_sel !== 2'b00) $display("FAIL reset wb_sel: got %b want 00", wb_sel);
      else passed++;
      total++;
      if (trap_cause !== 3'd0) $display("FAIL reset trap_cause: got %0d want 0", trap_cause);
      else passed++;
      total++;
      if (pc !== RESET_PC) $display("FAIL reset pc: got %h want %h", pc, RESET_PC);
      else passed++;
      total++;
      if (instret !== 32'd0) $display("FAIL reset instret: got %0d want 0", instret);
      else passed++;
   endtask

   task automatic test_alu();
      run_instr("addi", K_ALU, 1'b0, 32'h0, 0, 0);
      run_instr("fence", K_FENCE, 1'b0, 32'h0, 0, 0);
   endtask

   task automatic test_branch();
      run_instr("beq_taken", K_BRANCH, 1'b1, 32'h0000_0040, 0, 0);
      run_instr("bne_not_taken", K_BRANCH, 1'b0, 32'h0000_0080, 0, 0);
   endtask

   task automatic test_load_store();
      run_instr("lw_wait3", K_LOAD, 1'b0, 32'h0, 0, 3);
      run_instr("sw", K_STORE, 1'b0, 32'h0, 0, 0);
      run_instr("lw_wait15", K_LOAD, 1'b0, 32'h0, 1, MEM_TIMEOUT - 1);
   endtask

   task automatic test_jump();
      run_instr("jal_aligned", K_JUMP, 1'b0, 32'h0000_0100, 0, 0);
      run_instr("jal_misaligned", K_JUMP, 1'b0, 32'h0000_0102, 0, 0);
      do_resume("jal_misaligned");
      run_instr("beq_misaligned", K_BRANCH, 1'b1, 32'h0000_0201, 0, 0);
      do_resume("beq_misaligned");
   endtask

   task automatic test_system();
      run_instr("ecall", K_ECALL, 1'b0, 32'h0, 0, 0);
      do_resume("ecall");
      run_instr("ebreak", K_EBREAK, 1'b0, 32'h0, 2, 0);
      do_resume("ebreak");
      run_instr("illegal", K_NONE, 1'b0, 32'h0, 0, 0);
      do_resume("illegal");
   endtask

   task automatic test_timeout();
      run_instr("fetch_ready_16th", K_ALU, 1'b0, 32'h0, MEM_TIMEOUT - 1, 0);
      run_instr("fetch_timeout", K_ALU, 1'b0, 32'h0, NEVER, 0);
      do_resume("fetch_timeout");
      run_instr("mem_timeout", K_STORE, 1'b0, 32'h0, 0, NEVER);
      do_resume("mem_timeout");
   endtask

   task automatic test_back_to_back();
      run_instr("jal_top", K_JUMP, 1'b0, 32'hFFFF_FFFC, 0, 0);
      run_instr("alu_wrap", K_ALU, 1'b0, 32'h0, 0, 0);
      run_instr("lw_after_wrap", K_LOAD, 1'b0, 32'h0, 2, 0);
   endtask

   task automatic test_reset_mid_mem();
      int n;
      set_flags(K_LOAD);
      n = 0;
      while (!dmem_valid && (n < 20)) begin
         imem_ready = imem_valid;
         n++;
         @(negedge clk);
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      total++;
      if (dmem_valid !== 1'b1) $display("FAIL mid_mem reach: got dmem_valid %b want 1", dmem_valid);
      else passed++;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_pc = RESET_PC; m_instret = 32'd0;
      total++;
      if (pc !== RESET_PC) $display("FAIL mid_mem pc: got %h want %h", pc, RESET_PC);
      else passed++;
      total++;
      if ({imem_valid, dmem_valid} !== 2'b10) $display("FAIL mid_mem valids: got %b want 10", {imem_valid, dmem_valid});
      else passed++;
      total++;
      if (instret !== 32'd0) $display("FAIL mid_mem instret: got %0d want 0", instret);
      else passed++;
      run_instr("addi_after_reset", K_ALU, 1'b0, 32'h0, 0, 0);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      @(negedge clk);
      test_reset();
      test_alu();
      test_branch();
      test_load_store();
      test_jump();
      test_system();
      test_timeout();
      test_back_to_back();
      test_reset_mid_mem();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
